inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), value driven on inst while the buffer is empty.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imemReq  output  1  one-cycle request pulse to instruction memory.
REQ-006 imemAddr  output  32  fetch address, valid while imemReq=1.
REQ-007 imemValid  input  1  response strobe; one response per accepted request, at least 1 cycle after the request.
REQ-008 imemData  input  32  instruction word, valid while imemValid=1.
REQ-009 inst  output  32  instruction presented to the control decoder (buffer head).
REQ-010 instPc  output  32  PC of inst.
REQ-011 instValid  output  1  buffer head is valid.
REQ-012 instReady  input  1  decoder consumes the head when instValid=1 and instReady=1.
REQ-013 branchEn  input  1  redirect strobe from control/branch logic.
REQ-014 branchTarget  input  32  redirect address, sampled when branchEn=1.
REQ-015 fetchFault  output  1  misaligned redirect target; fetching halted.

Function
REQ-016 The block SHALL hold a 2-entry FIFO of {instruction, pc}, a fetch PC register, an outstanding flag and a discard flag.
REQ-017 States SHALL be FETCH (may issue), WAIT (one request outstanding) and FAULT.
REQ-018 In FETCH, imemReq SHALL pulse with imemAddr=PC when (count + outstanding) < 2; PC then advances by 4 and the state moves to WAIT.
REQ-019 At most one request SHALL be outstanding; no request is issued in WAIT or FAULT.
REQ-020 In WAIT, imemValid with discard=0 SHALL push {imemData, request address} into the FIFO and return to FETCH.
REQ-021 In WAIT, imemValid with discard=1 SHALL drop the data, clear discard and return to FETCH.
REQ-022 imemValid with no request outstanding SHALL be ignored.
REQ-023 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-024 The pop condition is instValid=1 and instReady=1; push and pop in the same cycle at count=1 SHALL leave count=1 with the new head.
REQ-025 instValid SHALL equal (count != 0), and inst SHALL equal NOP_INST whenever count=0.
REQ-026 branchEn=1 SHALL, on that edge, flush the FIFO, cancel any pop, load PC=branchTarget, and set discard if a request is outstanding.
REQ-027 A redirect SHALL take priority over a push or pop in the same cycle.
REQ-028 A redirect with branchTarget[1:0] != 0 SHALL enter FAULT with fetchFault=1.
REQ-029 FAULT SHALL be left only by an aligned redirect or by reset.
REQ-030 A response still outstanding when FAULT is entered SHALL be discarded.
REQ-031 With a 1-cycle memory, the first imemReq SHALL occur on the first rising edge after rst deasserts.
REQ-032 With a 1-cycle memory, instValid SHALL assert on the edge after imemValid.
REQ-033 With instReady held at 1 and a 1-cycle memory, sustained throughput SHALL be one instruction per 2 cycles.

Reset
REQ-034 While rst=1, all state SHALL be cleared immediately, regardless of clk.
REQ-035 Reset state: PC=RESET_PC, state=FETCH, count=0, outstanding=0, discard=0.
REQ-036 Reset outputs: imemReq=0, imemAddr=RESET_PC, instValid=0, inst=NOP_INST, instPc=RESET_PC, fetchFault=0.
REQ-037 Reset asserted while a request is outstanding SHALL abandon that request; a later stray imemValid SHALL be ignored.

Verification
REQ-038 Reset then 1-cycle memory returning addr+0x100, instReady=1 -> in-order instPc 0,4,8 with inst 0x100,0x104,0x108.
REQ-039 instReady=0 for 10 cycles -> exactly two requests (0,4), instValid=1, inst frozen at entry 0, no third imemReq until a pop.
REQ-040 branchEn=1 with target 0x200 while the request for 0x8 is outstanding -> the 0x8 data is dropped; the next instPc is 0x200.
REQ-041 branchEn=1 with target 0x202 -> fetchFault=1, no imemReq; then branchEn=1 with target 0x300 -> fetchFault=0 and a fetch is issued at 0x300.
REQ-042 Redirect to 0xFFFF_FFFC -> successive fetches at 0xFFFF_FFFC then 0x0000_0000.
REQ-043 rst asserted mid-WAIT, then a late imemValid -> no push occurs; instValid=0; the first request after release is at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Bundle of the fetch unit's bus signals: imem request/response, decoder hand-off and redirect.
// Decoder hand-off is valid/ready: the head transfers on a rising edge where instValid=1 and instReady=1;
// instValid/inst/instPc stay stable until that transfer or a redirect flush.
interface inst_fetch_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemData;
    logic [31:0] inst;
    logic [31:0] instPc;
    logic        instValid;
    logic        instReady;
    logic        branchEn;
    logic [31:0] branchTarget;
    logic        fetchFault;

    modport master (
        output imemReq, imemAddr, inst, instPc, instValid, fetchFault,
        input  imemValid, imemData, instReady, branchEn, branchTarget
    );

    modport slave (
        input  imemReq, imemAddr, inst, instPc, instValid, fetchFault,
        output imemValid, imemData, instReady, branchEn, branchTarget
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: single-outstanding imem requests feeding a 2-entry {inst, pc} buffer,
// with branch redirect, in-flight response discard and a sticky misaligned-target fault state.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] req_addr;
    logic        outstanding;
    logic        out_next;
    logic        discard;
    logic        disc_next;

    logic [31:0] fifo_inst [2];
    logic [31:0] fifo_pc   [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        issue;
    logic        push;
    logic        pop;
    logic        resp;
    logic        redirect;
    logic        misaligned;
    logic        empty;

    assign redirect   = bus.branchEn;
    assign misaligned = (bus.branchTarget[1:0] != 2'b00);
    assign resp       = bus.imemValid && outstanding;
    assign empty      = (count == 2'd0);
    assign pop        = !empty && bus.instReady && !redirect;

    // Next-state logic; a redirect overrides whatever the current state would do.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        out_next   = outstanding;
        disc_next  = discard;
        issue      = 1'b0;
        push       = 1'b0;
        if (redirect) begin
            pc_next = bus.branchTarget;
            if (resp) begin
                out_next  = 1'b0;
                disc_next = 1'b0;
            end else begin
                disc_next = outstanding;
            end
            if (misaligned) begin
                state_next = FAULT;
            end else if (out_next) begin
                state_next = WAIT;
            end else begin
                state_next = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (!rst && (count < 2'd2)) begin
                        issue      = 1'b1;
                        pc_next    = pc + 32'd4;
                        out_next   = 1'b1;
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (resp) begin
                        out_next   = 1'b0;
                        disc_next  = 1'b0;
                        push       = !discard;
                        state_next = FETCH;
                    end
                end
                FAULT: begin
                    // A response still in flight when the fault hit is retired and dropped.
                    if (resp) begin
                        out_next  = 1'b0;
                        disc_next = 1'b0;
                    end
                end
                default: begin
                    state_next = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            req_addr    <= RESET_PC;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            outstanding <= out_next;
            discard     <= disc_next;
            if (issue) begin
                req_addr <= pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_inst[i] <= NOP_INST;
                fifo_pc[i]   <= RESET_PC;
            end
        end else if (redirect) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_inst[wr_ptr] <= bus.imemData;
                fifo_pc[wr_ptr]   <= req_addr;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign bus.imemReq    = issue;
    assign bus.imemAddr   = pc;
    assign bus.instValid  = !empty;
    assign bus.inst       = empty ? NOP_INST : fifo_inst[rd_ptr];
    assign bus.instPc     = fifo_pc[rd_ptr];
    assign bus.fetchFault = (state == FAULT);
    assign state_dbg      = state;

    a_single_outstanding: assert property (@(posedge clk) disable iff (rst) issue |-> !outstanding);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> ((count != 2'd2) || pop));
    a_no_issue_in_fault: assert property (@(posedge clk) disable iff (rst) (state == FAULT) |-> !issue);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed-vector bench for inst_fetch: per-cycle input/expected-output table plus
// a hand-written mid-cycle reset sequence and a retire-order scoreboard.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] M_AUTO  = 2'd0;
  localparam logic [1:0] M_HOLD  = 2'd1;
  localparam logic [1:0] M_STRAY = 2'd2;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic [1:0]  mem;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic        fault;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [1:0]  state_dbg;
  inst_fetch_if bus();

  inst_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          n_vec;
  int          n_err;
  logic        mem_pend;
  logic [31:0] mem_addr;

  function automatic void add(input logic r, input logic rd, input logic b, input logic [31:0] t,
                              input logic [1:0] m, input logic q, input logic [31:0] a, input logic v,
                              input logic [31:0] ins, input logic [31:0] p, input logic f);
    vec_t x;
    x.rst = r; x.rdy = rd; x.br = b; x.tgt = t; x.mem = m;
    x.req = q; x.addr = a; x.iv = v; x.inst = ins; x.ipc = p; x.fault = f;
    vecs.push_back(x);
  endfunction

  function automatic void check(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endfunction

  // driver: inputs at negedge, 1-cycle memory answers the previous cycle's request
  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    rst              = v.rst;
    bus.instReady    = v.rdy;
    bus.branchEn     = v.br;
    bus.branchTarget = v.tgt;
    case (v.mem)
      M_AUTO: begin
        bus.imemValid = mem_pend;
        bus.imemData  = mem_addr + 32'h100;
        mem_pend      = 1'b0;
      end
      M_HOLD: begin
        bus.imemValid = 1'b0;
        bus.imemData  = 32'h0;
      end
      default: begin
        bus.imemValid = 1'b1;
        bus.imemData  = 32'hDEAD_BEEF;
        mem_pend      = 1'b0;
      end
    endcase
    #1;
    n_vec++;
    check(idx, "imemReq",    {31'b0, bus.imemReq},    {31'b0, v.req});
    check(idx, "imemAddr",   bus.imemAddr,            v.addr);
    check(idx, "instValid",  {31'b0, bus.instValid},  {31'b0, v.iv});
    check(idx, "inst",       bus.inst,                v.inst);
    check(idx, "fetchFault", {31'b0, bus.fetchFault}, {31'b0, v.fault});
    if (v.iv || v.rst) check(idx, "instPc", bus.instPc, v.ipc);
    if (bus.instValid && bus.instReady && !bus.branchEn) got_q.push_back(bus.inst);
    if (bus.imemReq) begin
      mem_pend = 1'b1;
      mem_addr = bus.imemAddr;
    end
  endtask

  initial begin
    int waited;
    n_vec = 0;
    n_err = 0;
    mem_pend = 1'b0;
    mem_addr = 32'h0;
    rst = 1'b1;
    bus.instReady = 1'b0;
    bus.branchEn = 1'b0;
    bus.branchTarget = 32'h0;
    bus.imemValid = 1'b0;
    bus.imemData = 32'h0;

    // in-order stream from reset, ready held high
    add(1,1,0,0,M_AUTO, 0,32'h0,0,NOP,32'h0,0);
    add(1,1,0,0,M_AUTO, 0,32'h0,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 1,32'h0,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 0,32'h4,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 1,32'h4,1,32'h100,32'h0,0);
    add(0,1,0,0,M_AUTO, 0,32'h8,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 1,32'h8,1,32'h104,32'h4,0);
    add(0,1,0,0,M_AUTO, 0,32'hC,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 1,32'hC,1,32'h108,32'h8,0);
    // back-pressure: buffer fills with 0 and 4, then stops requesting
    add(1,0,0,0,M_AUTO, 0,32'h0,0,NOP,32'h0,0);
    add(0,0,0,0,M_AUTO, 1,32'h0,0,NOP,32'h0,0);
    add(0,0,0,0,M_AUTO, 0,32'h4,0,NOP,32'h0,0);
    add(0,0,0,0,M_AUTO, 1,32'h4,1,32'h100,32'h0,0);
    add(0,0,0,0,M_AUTO, 0,32'h8,1,32'h100,32'h0,0);
    for (int i = 0; i < 6; i++) add(0,0,0,0,M_AUTO, 0,32'h8,1,32'h100,32'h0,0);
    add(0,1,0,0,M_AUTO, 0,32'h8,1,32'h100,32'h0,0);
    add(0,0,0,0,M_AUTO, 1,32'h8,1,32'h104,32'h4,0);
    // redirect to 0x200 while 0x8 is in flight
    add(0,0,1,32'h200,M_HOLD, 0,32'hC,1,32'h104,32'h4,0);
    add(0,0,0,0,M_AUTO, 0,32'h200,0,NOP,32'h0,0);
    add(0,0,0,0,M_AUTO, 1,32'h200,0,NOP,32'h0,0);
    add(0,0,0,0,M_AUTO, 0,32'h204,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 1,32'h204,1,32'h300,32'h200,0);
    // misaligned redirect (response arrives same cycle), then recovery to 0x300
    add(0,1,1,32'h202,M_AUTO, 0,32'h208,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 0,32'h202,0,NOP,32'h0,1);
    add(0,1,0,0,M_AUTO, 0,32'h202,0,NOP,32'h0,1);
    add(0,1,1,32'h300,M_AUTO, 0,32'h202,0,NOP,32'h0,1);
    add(0,1,0,0,M_AUTO, 1,32'h300,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 0,32'h304,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 1,32'h304,1,32'h400,32'h300,0);
    // address wrap at the top of memory
    add(0,1,1,32'hFFFF_FFFC,M_HOLD, 0,32'h308,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 0,32'hFFFF_FFFC,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 1,32'hFFFF_FFFC,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 0,32'h0,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 1,32'h0,1,32'hFC,32'hFFFF_FFFC,0);
    add(0,1,0,0,M_AUTO, 0,32'h4,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO, 1,32'h4,1,32'h100,32'h0,0);
    // reset mid-WAIT, stray responses during and after reset
    add(1,1,0,0,M_HOLD,  0,32'h0,0,NOP,32'h0,0);
    add(1,1,0,0,M_STRAY, 0,32'h0,0,NOP,32'h0,0);
    add(0,1,0,0,M_STRAY, 1,32'h0,0,NOP,32'h0,0);
    add(0,1,0,0,M_AUTO,  0,32'h4,0,NOP,32'h0,0);
    add(0,0,0,0,M_AUTO,  1,32'h4,1,32'h100,32'h0,0);
    // push and pop in the same cycle at count=1, then fill to full
    add(0,1,0,0,M_AUTO, 0,32'h8,1,32'h100,32'h0,0);
    add(0,0,0,0,M_AUTO, 1,32'h8,1,32'h104,32'h4,0);
    add(0,0,0,0,M_AUTO, 0,32'hC,1,32'h104,32'h4,0);
    add(0,0,0,0,M_AUTO, 0,32'hC,1,32'h104,32'h4,0);

    exp_q = '{32'h100, 32'h104, 32'h108, 32'h100, 32'h300, 32'h400, 32'hFC, 32'h100, 32'h100};

    foreach (vecs[i]) step(vecs[i], i);

    // hand sequence: asynchronous reset pulse between clock edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.instReady = 1'b0;
    bus.imemValid = 1'b0;
    mem_pend = 1'b0;
    #1;
    n_vec++;
    check(1000, "async_rst_instValid", {31'b0, bus.instValid}, 32'h0);
    check(1000, "async_rst_inst", bus.inst, NOP);
    check(1000, "async_rst_instPc", bus.instPc, 32'h0);
    check(1000, "async_rst_imemAddr", bus.imemAddr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    check(1001, "first_req", {31'b0, bus.imemReq}, 32'h1);
    check(1001, "first_req_addr", bus.imemAddr, 32'h0);
    @(negedge clk);
    bus.imemValid = 1'b1;
    bus.imemData = 32'h0000_0555;
    #1;
    n_vec++;
    check(1002, "no_req_while_wait", {31'b0, bus.imemReq}, 32'h0);
    check(1002, "not_valid_yet", {31'b0, bus.instValid}, 32'h0);
    @(negedge clk);
    bus.imemValid = 1'b0;
    #1;
    waited = 0;
    while (!bus.instValid && waited < 8) begin
      @(negedge clk);
      #1;
      waited++;
    end
    n_vec++;
    check(1003, "instValid_latency", waited, 0);
    check(1003, "first_inst", bus.inst, 32'h0000_0555);
    check(1003, "first_instPc", bus.instPc, 32'h0);

    // scoreboard: retire order
    n_vec++;
    check(2000, "retire_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check(2001 + i, "retire_inst", got_q[i], exp_q[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
